// File: rtl/axi4_wr_sink_pkg.sv
// Shared types and codes for the AXI4 write-burst sink.
package axi4_wr_sink_pkg;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi4_wr_sink_mem.sv
// Byte-enabled single-write-port memory with a registered debug read port.
module axi4_wr_sink_mem
  import axi4_wr_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  localparam int IDX_W     = $clog2(MEM_DEPTH),
  localparam int NLANES    = byte_lanes(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [NLANES-1:0]     wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NLANES; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read-before-write: a same-cycle write to raddr shows up one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_wr_burst_sink.sv
// AXI4 write-channel slave: accepts one AW/W burst at a time into a memory, returns B.
// Optional macro AXI4_WR_SINK_BACKPRESSURE_EN makes WREADY alternate 0,1,... in DATA.
module axi4_wr_burst_sink
  import axi4_wr_sink_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [ID_WIDTH-1:0]          AWID,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBURST,
  input  logic                         WVALID,
  output logic                         WREADY,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  input  logic [DATA_WIDTH/8-1:0]      WSTRB,
  input  logic                         WLAST,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic [ID_WIDTH-1:0]          BID,
  output logic [1:0]                   BRESP,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata,
  output logic [31:0]                  beat_cnt,
  output logic [15:0]                  err_cnt
);

  localparam int NLANES     = byte_lanes(DATA_WIDTH);
  localparam int LANE_SHIFT = $clog2(NLANES);
  localparam int IDX_W      = $clog2(MEM_DEPTH);

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [1:0]            flag_q, aw_flag;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q, beat_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  wr_phase;
  logic                  aw_fire, w_fire, b_fire;
  logic                  last_beat, burst_end, proto_err, addr_ok, mem_we;

  function automatic logic word_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (LANE_SHIFT + IDX_W)) == '0;
  endfunction

  assign aw_fire   = AWVALID && AWREADY;
  assign w_fire    = WVALID && WREADY;
  assign b_fire    = BVALID && BREADY;
  assign last_beat = (beat_q == len_q);
  assign burst_end = WLAST || last_beat;
  assign proto_err = (WLAST != last_beat);
  assign addr_ok   = word_in_range(addr_q);
  assign mem_we    = w_fire && (flag_q == BRESP_OKAY) && addr_ok;
  assign BID       = id_q;
  assign BRESP     = flag_q;

  // DECERR is applied last so it wins over any SLVERR cause.
  always_comb begin
    aw_flag = BRESP_OKAY;
    if (AWBURST == BURST_WRAP || AWBURST == 2'b11 || int'(AWSIZE) > LANE_SHIFT)
      aw_flag = BRESP_SLVERR;
    if (!word_in_range(AWADDR))
      aw_flag = BRESP_DECERR;
  end

`ifdef AXI4_WR_SINK_BACKPRESSURE_EN
  logic wr_phase_q;
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)             wr_phase_q <= 1'b0;
    else if (state_q != DATA) wr_phase_q <= 1'b0;
    else                      wr_phase_q <= ~wr_phase_q;
  end
  assign wr_phase = wr_phase_q;
`else
  assign wr_phase = 1'b1;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    unique case (state_q)
      IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) state_d = DATA;
      end
      DATA: begin
        WREADY = wr_phase;
        if (WVALID && wr_phase && burst_end) state_d = RESP;
      end
      RESP: begin
        BVALID = 1'b1;
        if (BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      id_q   <= '0;
      flag_q <= BRESP_OKAY;
    end else if (aw_fire) begin
      id_q   <= AWID;
      flag_q <= aw_flag;
    end else if (w_fire) begin
      if (!addr_ok)                                flag_q <= BRESP_DECERR;
      else if (proto_err && flag_q == BRESP_OKAY)  flag_q <= BRESP_SLVERR;
    end
  end

  // Burst context is fully reloaded on every AW, so it carries no reset.
  always_ff @(posedge ACLK) begin
    if (aw_fire) begin
      addr_q  <= AWADDR;
      len_q   <= AWLEN;
      size_q  <= AWSIZE;
      burst_q <= AWBURST;
      beat_q  <= '0;
    end else if (w_fire) begin
      beat_q <= beat_q + 8'd1;
      if (burst_q == BURST_INCR) addr_q <= addr_q + (ADDR_WIDTH'(1) << size_q);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      beat_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (w_fire) beat_cnt <= beat_cnt + 32'd1;
      if (b_fire && flag_q != BRESP_OKAY && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  axi4_wr_sink_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .we    (mem_we),
    .waddr (addr_q[LANE_SHIFT +: IDX_W]),
    .wstrb (WSTRB),
    .wdata (WDATA),
    .raddr (dbg_addr),
    .rdata (dbg_rdata)
  );

endmodule

// File: tb/tb_axi4_wr_burst_sink.sv
// Bench for axi4_wr_burst_sink: burst table plus hand-written corner sequences.
module tb_axi4_wr_burst_sink;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID, AWREADY;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        WVALID, WREADY, WLAST;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;
  logic [31:0] beat_cnt;
  logic [15:0] err_cnt;

  always #5 ACLK = ~ACLK;

  axi4_wr_burst_sink dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .beat_cnt(beat_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wlast_at;
    logic [3:0]  strb;
    logic [31:0] base;
    logic [1:0]  resp;
    bit          mw;
    bit          chk;
  } row_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  row_t        rows[10];
  bexp_t       sb[$];
  logic [31:0] exp_mem[256];
  bit          mvalid[256];
  logic [31:0] exp_beats;
  logic [15:0] exp_errs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic push_exp(input logic [3:0] id, input logic [1:0] resp);
    bexp_t e;
    e.id = id;
    e.resp = resp;
    sb.push_back(e);
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    int w;
    w = int'(a >> 2);
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    if (w < 256) begin
      exp_mem[w] = (exp_mem[w] & ~m) | (d & m);
      mvalid[w] = 1'b1;
    end
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int k;
    AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
    k = 0;
    while (!AWREADY && k < 50) begin @(posedge ACLK); #1; k++; end
    if (!AWREADY) timeout("aw_handshake");
    else begin @(posedge ACLK); #1; end
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    int k;
    WVALID = 1'b1; WDATA = d; WSTRB = s; WLAST = last;
    k = 0;
    while (!WREADY && k < 50) begin @(posedge ACLK); #1; k++; end
    if (!WREADY) timeout("w_handshake");
    else begin @(posedge ACLK); #1; exp_beats++; end
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic get_b();
    int k;
    bexp_t e;
    BREADY = 1'b1;
    k = 0;
    while (!BVALID && k < 50) begin @(posedge ACLK); #1; k++; end
    if (!BVALID || sb.size() == 0) timeout("b_handshake");
    else begin
      e = sb.pop_front();
      check("bid", 64'(BID), 64'(e.id));
      check("bresp", 64'(BRESP), 64'(e.resp));
      if (e.resp != 2'b00) exp_errs++;
      @(posedge ACLK); #1;
    end
    BREADY = 1'b0;
  endtask

  task automatic read_dbg(input int w, output logic [31:0] d);
    dbg_addr = 8'(w);
    @(posedge ACLK); #1;
    d = dbg_rdata;
  endtask

  task automatic check_word(input int w);
    logic [31:0] d;
    if (mvalid[w]) begin
      read_dbg(w, d);
      check($sformatf("mem[%0d]", w), 64'(d), 64'(exp_mem[w]));
    end
  endtask

  task automatic run_row(input row_t r);
    int nb;
    logic [31:0] a, d;
    push_exp(r.id, r.resp);
    send_aw(r.id, r.addr, r.len, r.size, r.burst);
    nb = (r.wlast_at <= int'(r.len)) ? r.wlast_at + 1 : int'(r.len) + 1;
    a = r.addr;
    for (int i = 0; i < nb; i++) begin
      d = r.base + 32'(i);
      send_w(d, r.strb, i == r.wlast_at);
      if (r.mw) model_write(a, d, r.strb);
      if (r.burst == 2'b01) a = a + (32'd1 << r.size);
    end
    get_b();
    check("beat_cnt", 64'(beat_cnt), 64'(exp_beats));
    check("err_cnt", 64'(err_cnt), 64'(exp_errs));
    if (r.chk) begin
      a = r.addr;
      for (int i = 0; i < nb; i++) begin
        if ((a >> 2) < 256) check_word(int'(a >> 2));
        if (r.burst == 2'b01) a = a + (32'd1 << r.size);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 64'(AWREADY), 64'd1);
    check({tag, "_wready"}, 64'(WREADY), 64'd0);
    check({tag, "_bvalid"}, 64'(BVALID), 64'd0);
    check({tag, "_bid"}, 64'(BID), 64'd0);
    check({tag, "_bresp"}, 64'(BRESP), 64'd0);
    check({tag, "_dbg_rdata"}, 64'(dbg_rdata), 64'd0);
    check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'd0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    int beats, cyc;
    logic first_wr;
    row_t r;

    //          id     addr          len   sz    burst  wl strb   base           resp   mw chk
    rows[0] = '{4'h3, 32'h0000_0010, 8'd3, 3'd2, 2'b01, 3, 4'hF, 32'h0000_00A0, 2'b00, 1, 1};
    rows[1] = '{4'h4, 32'h0000_0040, 8'd1, 3'd2, 2'b01, 1, 4'hF, 32'h0000_0055, 2'b00, 1, 1};
    rows[2] = '{4'h5, 32'h0000_0040, 8'd1, 3'd2, 2'b10, 1, 4'hF, 32'h0000_0077, 2'b10, 0, 1};
    rows[3] = '{4'h1, 32'h0000_0400, 8'd0, 3'd2, 2'b01, 0, 4'hF, 32'h0000_0099, 2'b11, 0, 0};
    rows[4] = '{4'h2, 32'h0000_0080, 8'd0, 3'd3, 2'b01, 0, 4'hF, 32'h0000_0033, 2'b10, 0, 0};
    rows[5] = '{4'h6, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 1, 4'hF, 32'h0000_0044, 2'b10, 0, 0};
    rows[6] = '{4'h8, 32'h0000_0120, 8'd1, 3'd2, 2'b01, 9, 4'hF, 32'h0000_0066, 2'b10, 0, 0};
    rows[7] = '{4'h9, 32'h0000_03F8, 8'd3, 3'd2, 2'b01, 3, 4'hF, 32'h0000_00C0, 2'b11, 1, 1};
    rows[8] = '{4'hA, 32'h0000_0010, 8'd1, 3'd2, 2'b01, 1, 4'h0, 32'h0000_00FF, 2'b00, 1, 1};
    rows[9] = '{4'hB, 32'h0000_0014, 8'd0, 3'd2, 2'b01, 0, 4'h6, 32'hBBCC_DD00, 2'b00, 1, 1};

    for (int i = 0; i < 256; i++) begin exp_mem[i] = '0; mvalid[i] = 1'b0; end
    exp_beats = '0; exp_errs = '0;

    ARESETn = 1'b0;
    AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0; dbg_addr = 0;
    repeat (3) @(posedge ACLK);
    #1;
    check_reset_outputs("reset");
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // W presented with no AW must be ignored
    WVALID = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WLAST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("idle_wready", 64'(WREADY), 64'd0);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check("idle_beat_cnt", 64'(beat_cnt), 64'd0);

    for (int i = 0; i < 10; i++) begin
      r = rows[i];
      run_row(r);
    end

    // FIXED burst merging two half-word strobes into one word
    push_exp(4'h7, 2'b00);
    send_aw(4'h7, 32'h8, 8'd1, 3'd2, 2'b00);
    send_w(32'h1111_1111, 4'h3, 1'b0);
    send_w(32'h2222_2222, 4'hC, 1'b1);
    get_b();
    read_dbg(2, d);
    check("fixed_word2", 64'(d), 64'h2222_1111);
    exp_mem[2] = 32'h2222_1111; mvalid[2] = 1'b1;

    // BREADY stall: response must hold steady and no new AW accepted
    push_exp(4'hC, 2'b00);
    send_aw(4'hC, 32'h200, 8'd0, 3'd2, 2'b01);
    send_w(32'h5A5A_5A5A, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("stall_bvalid", 64'(BVALID), 64'd1);
      check("stall_bid", 64'(BID), 64'hC);
      check("stall_bresp", 64'(BRESP), 64'd0);
      check("stall_awready", 64'(AWREADY), 64'd0);
      @(posedge ACLK); #1;
    end
    get_b();
    check("post_b_awready", 64'(AWREADY), 64'd1);

    // Reset mid-burst: two beats land, then the burst is dropped
    send_aw(4'hD, 32'h300, 8'd3, 3'd2, 2'b01);
    send_w(32'hE0, 4'hF, 1'b0);
    send_w(32'hE1, 4'hF, 1'b0);
    model_write(32'h300, 32'hE0, 4'hF);
    model_write(32'h304, 32'hE1, 4'hF);
    ARESETn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    exp_beats = '0; exp_errs = '0;
    r = '{4'hE, 32'h0000_0308, 8'd1, 3'd2, 2'b01, 1, 4'hF, 32'h0000_00F0, 2'b00, 1, 1};
    run_row(r);
    check_word(192);
    check_word(193);

    // WREADY pacing over an 8-beat burst
    push_exp(4'h2, 2'b00);
    send_aw(4'h2, 32'h180, 8'd7, 3'd2, 2'b01);
    first_wr = WREADY;
    beats = 0; cyc = 0;
    WVALID = 1'b1; WSTRB = 4'hF;
    while (beats < 8 && cyc < 40) begin
      WDATA = 32'hB0 + 32'(beats);
      WLAST = (beats == 7);
      if (WREADY) begin
        model_write(32'h180 + 32'(beats * 4), WDATA, 4'hF);
        beats++;
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    exp_beats += 32'(beats);
    check("pace_beats", 64'(beats), 64'd8);
`ifdef AXI4_WR_SINK_BACKPRESSURE_EN
    check("pace_first_wready", 64'(first_wr), 64'd0);
    check("pace_cycles", 64'(cyc), 64'd16);
`else
    check("pace_first_wready", 64'(first_wr), 64'd1);
    check("pace_cycles", 64'(cyc), 64'd8);
`endif
    get_b();
    check("pace_beat_cnt", 64'(beat_cnt), 64'(exp_beats));
    for (int i = 96; i < 104; i++) check_word(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
